cache_ctrl_dm: RTL

- Direct-mapped, write-through, no-write-allocate cache controller between the CPU load/store port and the 4-word-block data memory.
- Holds the tag/valid/data arrays internally.
- Serves hits in one cycle.
- On a read miss, drives the memory's read request plus the four block addresses, waits for memory ready, then refills the line.
- Stores always go to memory (one-cycle write) and update the line only on a hit.

---
 rtl/cache_ctrl_dm.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller with 4-word blocks.
// Define CACHE_CTRL_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_ctrl_dm #(
  parameter int WORD     = 32,
  parameter int ADDRESSL = 15,
  parameter int INDEXL   = 10,
  parameter int OFFSETL  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [ADDRESSL-1:0] cpu_addr,
  input  logic [WORD-1:0]     cpu_wdata,
  output logic [WORD-1:0]     cpu_rdata,
  output logic                cpu_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDRESSL-1:0] mem_addr,
  output logic [ADDRESSL-1:0] mem_addr0,
  output logic [ADDRESSL-1:0] mem_addr1,
  output logic [ADDRESSL-1:0] mem_addr2,
  output logic [ADDRESSL-1:0] mem_addr3,
  output logic [WORD-1:0]     mem_wdata,
  input  logic [WORD-1:0]     mem_block0,
  input  logic [WORD-1:0]     mem_block1,
  input  logic [WORD-1:0]     mem_block2,
  input  logic [WORD-1:0]     mem_block3,
  input  logic                mem_ready
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  localparam int TAGL  = ADDRESSL - INDEXL - OFFSETL;
  localparam int LINES = 1 << INDEXL;
  localparam int WORDS = 1 << OFFSETL;

  typedef enum logic [2:0] {IDLE, RD_MISS, REFILL, WR_MEM, DONE} state_t;

  state_t state_reg, state_next;

  logic [ADDRESSL-1:0] addr_reg;
  logic [WORD-1:0]     wdata_reg;
  logic [LINES-1:0]    valid_reg;
  logic [TAGL-1:0]     tag_mem [LINES];

  logic [OFFSETL-1:0]  cpu_off, lat_off;
  logic [INDEXL-1:0]   cpu_idx, lat_idx;
  logic [TAGL-1:0]     cpu_tag, lat_tag;
  logic                cpu_hit, lat_hit;
  logic                rd_accept;

  logic [WORD-1:0]     blk_in     [WORDS];
  logic [WORD-1:0]     line_word  [WORDS];
  logic [WORD-1:0]     bank_wdata [WORDS];
  logic [WORDS-1:0]    bank_we;

  assign cpu_off = cpu_addr[OFFSETL-1:0];
  assign cpu_idx = cpu_addr[INDEXL+OFFSETL-1:OFFSETL];
  assign cpu_tag = cpu_addr[ADDRESSL-1:INDEXL+OFFSETL];
  assign lat_off = addr_reg[OFFSETL-1:0];
  assign lat_idx = addr_reg[INDEXL+OFFSETL-1:OFFSETL];
  assign lat_tag = addr_reg[ADDRESSL-1:INDEXL+OFFSETL];

  // Lookup must resolve in the request cycle, so tag and data reads are combinational.
  assign cpu_hit = valid_reg[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign lat_hit = valid_reg[lat_idx] && (tag_mem[lat_idx] == lat_tag);

  assign rd_accept = (state_reg == IDLE) && !cpu_write && cpu_read;

  assign blk_in[0] = mem_block0;
  assign blk_in[1] = mem_block1;
  assign blk_in[2] = mem_block2;
  assign blk_in[3] = mem_block3;

  // One bank per word-in-block so a refill writes the whole line in one cycle.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_bank
      logic [WORD-1:0] bank [LINES];

      assign bank_we[gi] = (state_reg == REFILL) ||
                           ((state_reg == WR_MEM) && lat_hit && (lat_off == OFFSETL'(gi)));
      assign bank_wdata[gi] = (state_reg == REFILL) ? blk_in[gi] : wdata_reg;
      assign line_word[gi]  = bank[cpu_idx];

      always_ff @(posedge clk) begin
        if (bank_we[gi]) begin
          bank[lat_idx] <= bank_wdata[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (state_reg == REFILL) begin
      tag_mem[lat_idx] <= lat_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_write) begin
          state_next = WR_MEM;
        end else if (cpu_read) begin
          state_next = cpu_hit ? DONE : RD_MISS;
        end
      end
      RD_MISS: begin
        if (mem_ready) begin
          state_next = REFILL;
        end
      end
      REFILL:  state_next = DONE;
      WR_MEM:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      cpu_rdata <= '0;
      valid_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu_write) begin
            addr_reg  <= cpu_addr;
            wdata_reg <= cpu_wdata;
          end else if (cpu_read) begin
            addr_reg <= cpu_addr;
            if (cpu_hit) begin
              cpu_rdata <= line_word[cpu_off];
            end
          end
        end
        REFILL: begin
          valid_reg[lat_idx] <= 1'b1;
          cpu_rdata          <= blk_in[lat_off];
        end
        default: ;
      endcase
    end
  end

  assign cpu_ready = (state_reg == DONE);
  assign mem_read  = (state_reg == RD_MISS) || (state_reg == REFILL);
  assign mem_write = (state_reg == WR_MEM);

  // Address/data buses idle at zero so reset and IDLE look identical on the memory side.
  assign mem_addr  = (mem_read || mem_write) ? addr_reg : '0;
  assign mem_addr0 = mem_read ? {addr_reg[ADDRESSL-1:OFFSETL], OFFSETL'(0)} : '0;
  assign mem_addr1 = mem_read ? {addr_reg[ADDRESSL-1:OFFSETL], OFFSETL'(1)} : '0;
  assign mem_addr2 = mem_read ? {addr_reg[ADDRESSL-1:OFFSETL], OFFSETL'(2)} : '0;
  assign mem_addr3 = mem_read ? {addr_reg[ADDRESSL-1:OFFSETL], OFFSETL'(3)} : '0;
  assign mem_wdata = mem_write ? wdata_reg : '0;

`ifdef CACHE_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rd_accept) begin
      if (cpu_hit) begin
        if (hit_count != 32'hFFFF_FFFF) begin
          hit_count <= hit_count + 32'd1;
        end
      end else if (miss_count != 32'hFFFF_FFFF) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  logic unused_rd_accept;
  assign unused_rd_accept = rd_accept;
`endif

endmodule
